// File: rtl/pid_sample_ctrl.sv
// Sequencing stage around the PID increment datapath: forms e(k), keeps the
// e(k-1)/e(k-2) history, integrates the returned increment with clamping and hands u(k) downstream.
module pid_sample_ctrl #(
    parameter int DW = 16,
    parameter int OW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pid_clr,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic [DW-1:0] setpoint,
    input  logic [DW-1:0] feedback,
    output logic [DW-1:0] ek0,
    output logic [DW-1:0] ek1,
    output logic [DW-1:0] ek2,
    input  logic [OW-1:0] d_uk,
    input  logic [OW-1:0] u_min,
    input  logic [OW-1:0] u_max,
    output logic [OW-1:0] uk,
    output logic          uk_valid,
    input  logic          uk_ready,
    output logic          busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a source holds its data and valid until that edge, and ready
    // never depends combinationally on valid.

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        INC  = 3'd2,
        ACC  = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [DW-1:0] EMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] EMIN = {1'b1, {(DW-1){1'b0}}};

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] sp_q;
    logic [DW-1:0] fb_q;
    logic [OW-1:0] inc_q;

    logic [DW:0]   err_diff;
    logic [DW-1:0] err_sat;
    logic [OW:0]   acc_sum;
    logic [OW:0]   umax_x;
    logic [OW:0]   umin_x;
    logic [OW:0]   acc_hi;
    logic [OW-1:0] acc_clamped;

    logic          clr;

    assign clr          = rst | pid_clr;
    assign sample_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_valid) state_nxt = ERR;
            ERR:     state_nxt = INC;
            INC:     state_nxt = ACC;
            ACC:     state_nxt = OUT;
            OUT:     if (uk_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Error: one extra bit of headroom, then saturate back to DW bits.
    always_comb begin
        err_diff = {sp_q[DW-1], sp_q} - {fb_q[DW-1], fb_q};
        if (err_diff[DW] != err_diff[DW-1]) begin
            err_sat = err_diff[DW] ? EMIN : EMAX;
        end else begin
            err_sat = err_diff[DW-1:0];
        end
    end

    // Upper limit first, then lower, so an inverted window resolves to u_min.
    always_comb begin
        acc_sum = {uk[OW-1], uk} + {inc_q[OW-1], inc_q};
        umax_x  = {u_max[OW-1], u_max};
        umin_x  = {u_min[OW-1], u_min};
        if ($signed(acc_sum) > $signed(umax_x)) begin
            acc_hi = umax_x;
        end else begin
            acc_hi = acc_sum;
        end
        if ($signed(acc_hi) < $signed(umin_x)) begin
            acc_clamped = u_min;
        end else begin
            acc_clamped = acc_hi[OW-1:0];
        end
    end

    // Datapath registers, each loaded only in its owning state.
    always_ff @(posedge clk) begin
        if (clr) begin
            sp_q     <= '0;
            fb_q     <= '0;
            inc_q    <= '0;
            ek0      <= '0;
            ek1      <= '0;
            ek2      <= '0;
            uk       <= '0;
            uk_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        sp_q <= setpoint;
                        fb_q <= feedback;
                    end
                end
                ERR: begin
                    ek0 <= err_sat;
                end
                INC: begin
                    inc_q <= d_uk;
                end
                ACC: begin
                    uk       <= acc_clamped;
                    uk_valid <= 1'b1;
                end
                OUT: begin
                    // History shifts only once the result has been taken.
                    if (uk_valid && uk_ready) begin
                        uk_valid <= 1'b0;
                        ek2      <= ek1;
                        ek1      <= ek0;
                    end
                end
                default: begin
                    uk_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_sample_ctrl.sv
// Self-checking bench for pid_sample_ctrl: a behavioural PID increment model
// drives d_uk, and a scoreboard queue holds the expected u(k) of every sample.
module tb_pid_sample_ctrl;

    localparam int DW = 16;
    localparam int OW = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 pid_clr = 1'b0;
    logic                 sample_valid = 1'b0;
    logic                 sample_ready;
    logic signed [DW-1:0] setpoint = '0;
    logic signed [DW-1:0] feedback = '0;
    logic signed [DW-1:0] ek0, ek1, ek2;
    logic signed [OW-1:0] d_uk;
    logic signed [OW-1:0] u_min = -32'sd100000;
    logic signed [OW-1:0] u_max = 32'sd100000;
    logic signed [OW-1:0] uk;
    logic                 uk_valid;
    logic                 uk_ready = 1'b0;
    logic                 busy;

    pid_sample_ctrl #(.DW(DW), .OW(OW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pid_clr      (pid_clr),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .setpoint     (setpoint),
        .feedback     (feedback),
        .ek0          (ek0),
        .ek1          (ek1),
        .ek2          (ek2),
        .d_uk         (d_uk),
        .u_min        (u_min),
        .u_max        (u_max),
        .uk           (uk),
        .uk_valid     (uk_valid),
        .uk_ready     (uk_ready),
        .busy         (busy)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in increment datapath: kp = 2, ki = 1, kd = 0, or a forced value.
    bit                   duk_force = 1'b0;
    logic signed [OW-1:0] duk_val = '0;
    logic signed [OW-1:0] e0x, e1x;
    assign e0x  = OW'(ek0);
    assign e1x  = OW'(ek1);
    assign d_uk = duk_force ? duk_val : (3 * e0x - 2 * e1x);

    // Scoreboard and reference model state
    logic [OW-1:0] exp_q[$];
    int     vectors = 0;
    int     errors = 0;
    longint m_u = 0;
    int     m_e = 0;
    int     m_e1 = 0;
    int     m_e2 = 0;
    int     hs_cyc = 0;
    int     prev_hs = 0;

    function automatic int sat_err(input int sp, input int fb);
        int d;
        d = sp - fb;
        if (d > 32767) return 32767;
        if (d < -32768) return -32768;
        return d;
    endfunction

    function automatic longint clamp_u(input longint s, input longint lo, input longint hi);
        longint r;
        r = s;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    // Driver tasks
    task automatic do_reset(input bit use_clr);
        if (use_clr) pid_clr = 1'b1;
        else rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pid_clr = 1'b0;
        m_u = 0; m_e = 0; m_e1 = 0; m_e2 = 0;
    endtask

    // Accepts one sample and follows it to T+4, leaving the DUT in OUT.
    task automatic send(input int sp, input int fb, input bit frc, input longint fv);
        int     n;
        int     e;
        longint d;
        n = 0;
        e = sat_err(sp, fb);
        d = frc ? fv : (3 * longint'(e) - 2 * longint'(m_e1));
        m_u = clamp_u(m_u + d, longint'(u_min), longint'(u_max));
        m_e = e;
        exp_q.push_back(m_u[OW-1:0]);
        while (!sample_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sample_ready) begin
            vectors++; errors++;
            $display("FAIL ready_timeout got sample_ready=%b exp 1", sample_ready);
        end
        setpoint = sp[DW-1:0];
        feedback = fb[DW-1:0];
        duk_force = frc;
        duk_val = fv[OW-1:0];
        sample_valid = 1'b1;
        @(posedge clk); #1;
        prev_hs = hs_cyc;
        hs_cyc = cyc;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (ek0 !== e[DW-1:0] || ek1 !== m_e1[DW-1:0] || ek2 !== m_e2[DW-1:0]) begin
            errors++;
            $display("FAIL err_history got ek0=%0d ek1=%0d ek2=%0d exp %0d %0d %0d",
                     ek0, ek1, ek2, e, m_e1, m_e2);
        end
        @(posedge clk); #1;
        vectors++;
        if (uk_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid got uk_valid=%b exp 0 at T+3", uk_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (uk_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency got uk_valid=%b exp 1 at T+4", uk_valid);
        end
    endtask

    // Holds uk_ready low for 'hold' cycles, then takes one result from OUT.
    task automatic collect(input int hold, input bit poke);
        logic [OW-1:0] held;
        logic [OW-1:0] exp;
        bit            stable;
        held = uk;
        stable = 1'b1;
        uk_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 2) begin
                setpoint = 16'sd1234;
                feedback = -16'sd1234;
                sample_valid = 1'b1;
            end
            @(posedge clk); #1;
            sample_valid = 1'b0;
            if (uk !== held || uk_valid !== 1'b1 || sample_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        if (hold > 0) begin
            vectors++;
            if (!stable) begin
                errors++;
                $display("FAIL hold_stable got uk=%0d valid=%b ready=%b exp uk=%0d held",
                         uk, uk_valid, sample_ready, $signed(held));
            end
        end
        uk_ready = 1'b1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        vectors++;
        if (uk !== exp) begin
            errors++;
            $display("FAIL uk_out got %0d exp %0d", uk, $signed(exp));
        end
        @(posedge clk); #1;
        uk_ready = 1'b0;
        vectors++;
        if (uk_valid !== 1'b0 || sample_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL return_idle got valid=%b ready=%b busy=%b exp 0 1 0",
                     uk_valid, sample_ready, busy);
        end
        m_e2 = m_e1;
        m_e1 = m_e;
    endtask

    // Scenario tasks
    task automatic test_reset;
        do_reset(1'b0);
        vectors++;
        if (uk !== 0 || uk_valid !== 0 || ek0 !== 0 || ek1 !== 0 || ek2 !== 0 ||
            sample_ready !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL reset_state got uk=%0d v=%b ek=%0d/%0d/%0d rdy=%b busy=%b exp all 0, rdy 1",
                     uk, uk_valid, ek0, ek1, ek2, sample_ready, busy);
        end
        u_min = -32'sd100000; u_max = 32'sd100000;
        send(100, 20, 1'b1, 500);
        uk_ready = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (uk !== 500 || uk_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_out got uk=%0d v=%b exp 500 1", uk, uk_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (uk !== 0 || uk_valid !== 0 || ek0 !== 0 || ek1 !== 0 || ek2 !== 0 ||
            sample_ready !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL reset_mid_out got uk=%0d v=%b ek=%0d/%0d/%0d rdy=%b busy=%b exp all 0, rdy 1",
                     uk, uk_valid, ek0, ek1, ek2, sample_ready, busy);
        end
        void'(exp_q.pop_back());
        m_u = 0; m_e = 0; m_e1 = 0; m_e2 = 0;
    endtask

    task automatic test_first_period;
        send(100, 40, 1'b0, 0);
        collect(0, 1'b0);
        vectors++;
        if (uk !== 180) begin
            errors++;
            $display("FAIL first_period_uk got %0d exp 180", uk);
        end
    endtask

    task automatic test_history;
        send(100, 70, 1'b0, 0);
        collect(0, 1'b0);
        vectors++;
        if (uk !== 150) begin
            errors++;
            $display("FAIL second_period_uk got %0d exp 150", uk);
        end
        send(100, 100, 1'b0, 0);
        collect(0, 1'b0);
        vectors++;
        if (ek1 !== 0 || ek2 !== 30) begin
            errors++;
            $display("FAIL history_shift got ek1=%0d ek2=%0d exp 0 30", ek1, ek2);
        end
    endtask

    task automatic test_saturation;
        do_reset(1'b0);
        u_min = -32'sd100000; u_max = 32'sd100000;
        send(32767, -32768, 1'b1, 0);
        collect(0, 1'b0);
        vectors++;
        if (ek0 !== 16'sd32767) begin
            errors++;
            $display("FAIL err_sat_pos got %0d exp 32767", ek0);
        end
        send(-32768, 32767, 1'b1, 0);
        collect(0, 1'b0);
        vectors++;
        if (ek0 !== -16'sd32768) begin
            errors++;
            $display("FAIL err_sat_neg got %0d exp -32768", ek0);
        end
        send(0, 0, 1'b1, 900);
        collect(0, 1'b0);
        u_max = 32'sd1000;
        send(0, 0, 1'b1, 400);
        collect(0, 1'b0);
        vectors++;
        if (uk !== 1000) begin
            errors++;
            $display("FAIL clamp_max got %0d exp 1000", uk);
        end
        do_reset(1'b0);
        u_max = 32'sd100000; u_min = -32'sd50;
        send(0, 0, 1'b1, -80);
        collect(0, 1'b0);
        vectors++;
        if (uk !== -50) begin
            errors++;
            $display("FAIL clamp_min got %0d exp -50", uk);
        end
        u_min = 32'sd200; u_max = 32'sd100;
        send(0, 0, 1'b1, 0);
        collect(0, 1'b0);
        vectors++;
        if (uk !== 200) begin
            errors++;
            $display("FAIL clamp_inverted got %0d exp 200", uk);
        end
    endtask

    task automatic test_backpressure;
        do_reset(1'b0);
        u_min = -32'sd100000; u_max = 32'sd100000;
        send(50, 10, 1'b0, 0);
        collect(6, 1'b1);
        vectors++;
        if (uk !== 120) begin
            errors++;
            $display("FAIL backpressure_uk got %0d exp 120", uk);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || ek0 !== 40) begin
            errors++;
            $display("FAIL poke_ignored got busy=%b ek0=%0d exp 0 40", busy, ek0);
        end
    endtask

    task automatic test_clear;
        int  n;
        bit  seen;
        do_reset(1'b0);
        send(100, 40, 1'b0, 0);
        collect(0, 1'b0);
        setpoint = 16'sd100; feedback = 16'sd70; duk_force = 1'b0;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        pid_clr = 1'b1;
        @(posedge clk); #1;
        pid_clr = 1'b0;
        vectors++;
        if (uk !== 0 || ek0 !== 0 || ek1 !== 0 || ek2 !== 0 || busy !== 0 || sample_ready !== 1) begin
            errors++;
            $display("FAIL clr_in_inc got uk=%0d ek=%0d/%0d/%0d busy=%b rdy=%b exp 0s, rdy 1",
                     uk, ek0, ek1, ek2, busy, sample_ready);
        end
        seen = 1'b0;
        n = 0;
        while (n < 8) begin
            if (uk_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL clr_no_valid got uk_valid=1 exp 0 after pid_clr");
        end
        m_u = 0; m_e = 0; m_e1 = 0; m_e2 = 0;
        send(100, 40, 1'b0, 0);
        collect(0, 1'b0);
        vectors++;
        if (uk !== 180) begin
            errors++;
            $display("FAIL after_clr_uk got %0d exp 180", uk);
        end
    endtask

    task automatic test_back_to_back;
        int sp;
        int fb;
        do_reset(1'b1);
        u_max = 32'($urandom_range(500, 3000));
        u_min = -32'($urandom_range(500, 3000));
        send(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000, 1'b0, 0);
        collect(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sp = int'($urandom_range(0, 4000)) - 2000;
            fb = int'($urandom_range(0, 4000)) - 2000;
            send(sp, fb, 1'b0, 0);
            vectors++;
            if (hs_cyc - prev_hs !== 5) begin
                errors++;
                $display("FAIL period got %0d cycles exp 5", hs_cyc - prev_hs);
            end
            collect(0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            send(int'($urandom_range(0, 60000)) - 30000, int'($urandom_range(0, 60000)) - 30000, 1'b0, 0);
            collect(int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_period();
        test_history();
        test_saturation();
        test_backpressure();
        test_clear();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
